array_access_arbiter: RTL and testbench
=======================================

# array_access_arbiter

Arbitrated, sequenced owner of a DEPTH x WIDTH register array shared by two requesters. It zero-initialises the array after reset, services one read or write per cycle with round-robin fairness between client 0 and client 1, and runs a bulk clear on command. It sits between generated FSM modules that need shared array storage and the storage itself, so no client ever drives the array directly.

## Interface
Parameters:
- WIDTH, 32, data width of each entry
- DEPTH, 8, number of entries (power of two, at least 2)
- ADDR_W, 3, address width, equal to log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0 / req1  input  1  client access request, held until granted
- we0 / we1  input  1  1 = write, 0 = read; valid while req is high
- addr0 / addr1  input  ADDR_W  entry index
- wdata0 / wdata1  input  WIDTH  write data
- gnt0 / gnt1  output  1  combinational grant; access commits at the clock edge where req&gnt
- rdata0 / rdata1  output  WIDTH  registered read data per client
- rvalid0 / rvalid1  output  1  one-cycle pulse, cycle after a granted read
- clear  input  1  single-cycle bulk-clear request
- ready  output  1  high in SERVE state only

## Operation
- Storage: internal array mem[DEPTH-1:0] of WIDTH bits. Only this block reads or writes it.
- States: INIT, SERVE, CLEAR. A 3-bit (ADDR_W) sweep counter cnt is used by INIT and CLEAR.
- Reset (async, any time): state=INIT, cnt=0, rr_last=1, rdata0/1=0, rvalid0/1=0. gnt0/1 and ready are 0 because state≠SERVE. An in-flight access is dropped, and INIT restarts from entry 0.
- INIT / CLEAR: each edge writes mem[cnt]=0 and cnt++. On the edge where cnt==DEPTH-1: cnt→0, state→SERVE. No grants are issued. clear is ignored in these states.
- SERVE with clear=1: state→CLEAR, cnt=0, gnt0=gnt1=0 that cycle, so no access commits. clear has priority over requests.
- SERVE with clear=0, grant rules:
  - only req0 → gnt0
  - only req1 → gnt1
  - both → the client ≠ rr_last
  - neither → none
- Granted client k at the edge:
  - if we_k: mem[addr_k]←wdata_k
  - else: rdata_k←mem[addr_k] and rvalid_k←1
  - rr_last←k
- rvalid_k clears on every edge without a granted read for client k. rdata_k holds its value otherwise.
- A write committed at edge N is visible to a read committed at edge N+1. At most one access per cycle, so there are no write/read collisions.
- A client may keep req high across consecutive cycles. Each edge with gnt consumes one access, and the client presents the next request on the following cycle.

## Timing
- Reset release → INIT occupies DEPTH edges. ready=1 after the DEPTH-th edge (8 edges by default).
- Write latency: 0 extra cycles. The entry is updated at the granting edge.
- Read latency: 1. rdata/rvalid are valid during the cycle after the granting edge.
- Clear: the cycle clear is sampled has ready=1 and no grant. ready=0 for the next DEPTH cycles. SERVE resumes after the DEPTH-th CLEAR edge.
- Contention with both requesters continuously active: grants alternate 0,1,0,1… Client 0 wins the first contended cycle after reset.
- Requests pending during INIT/CLEAR are neither granted nor lost. The client keeps req high until ready and gnt.

## Test plan
- Post-reset init: preload via writes, assert reset, release. Check ready=0 for 8 cycles, then 1. Reads of all 8 entries return 0 with rvalid pulsing once each.
- Single-client write/read: client 0 writes 0xDEADBEEF to addr 5, then reads addr 5. Check gnt0 is high both cycles and rdata0=0xDEADBEEF with rvalid0=1 exactly one cycle after the read grant.
- Round-robin: req0 and req1 both held high for 6 cycles with writes to addr 0 and addr 1 respectively. Check grants are 0,1,0,1,0,1, that no grant overlaps, and that the final contents match.
- Clear priority: in SERVE, assert clear and req1 (write 0x1234 to addr 2) together. Check gnt1=0 that cycle, ready low for 8 cycles, and that req1 is then granted and mem[2] reads 0x1234 while the other entries read 0.
- Reset mid-clear: assert reset at CLEAR cnt=3. Check outputs are zero immediately (async) and INIT restarts at entry 0 for a full 8 cycles.
- Read-after-write back-to-back: client 1 writes 0xA5A5A5A5 to addr 7 at edge N and reads addr 7 at edge N+1. Check rdata1=0xA5A5A5A5 at cycle N+2.

Source files
------------

// File: rtl/array_access_arbiter.sv
// Round-robin arbiter that owns a DEPTH x WIDTH register array.
// Ports: clk/reset; req/we/addr/wdata/gnt/rdata/rvalid per client; clear; ready.
module array_access_arbiter #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    input  logic              clear,
    output logic              ready
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_SERVE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_rr_last;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic w_serve;
    logic w_go;

    assign w_serve = (r_state == S_SERVE);
    // clear wins over any request in the cycle it is sampled
    assign w_go    = w_serve & ~clear;
    // on contention, the client that was not granted last wins
    assign gnt0    = w_go & req0 & (~req1 | r_rr_last);
    assign gnt1    = w_go & req1 & (~req0 | ~r_rr_last);
    assign ready   = w_serve;

    // storage is deliberately not reset; INIT sweeps it to zero
    always_ff @(posedge clk) begin
        if (!w_serve) begin
            r_mem[r_cnt] <= '0;
        end else if (gnt0 & we0) begin
            r_mem[addr0] <= wdata0;
        end else if (gnt1 & we1) begin
            r_mem[addr1] <= wdata1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_rr_last <= 1'b1;
            rdata0    <= '0;
            rdata1    <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 & ~we0) begin
                rdata0 <= r_mem[addr0];
            end
            if (gnt1 & ~we1) begin
                rdata1 <= r_mem[addr1];
            end
            if (gnt0) begin
                r_rr_last <= 1'b0;
            end else if (gnt1) begin
                r_rr_last <= 1'b1;
            end
            case (r_state)
                S_INIT, S_CLEAR: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SERVE;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                S_SERVE: begin
                    if (clear) begin
                        r_cnt   <= '0;
                        r_state <= S_CLEAR;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_access_arbiter.sv
// Directed bench for array_access_arbiter.
// Vector table for serve-phase traffic plus hand sequences for reset/init.
module tb_array_access_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [2:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic        clear = 1'b0;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    array_access_arbiter #(.WIDTH(32), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .clear(clear), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, w0;
        logic [2:0]  a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [2:0]  a1;
        logic [31:0] d1;
        logic        clr;
        logic        eg0, eg1, erdy;
        logic        ev0;
        logic [31:0] ed0;
        logic        ev1;
        logic [31:0] ed1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic r0, logic w0, logic [2:0] a0, logic [31:0] d0,
        logic r1, logic w1, logic [2:0] a1, logic [31:0] d1,
        logic clr, logic eg0, logic eg1, logic erdy,
        logic ev0, logic [31:0] ed0, logic ev1, logic [31:0] ed1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.clr = clr; v.eg0 = eg0; v.eg1 = eg1; v.erdy = erdy;
        v.ev0 = ev0; v.ed0 = ed0; v.ev1 = ev1; v.ed1 = ed1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; clear = 0;
    endtask

    // drive on negedge, check grants before the edge, results after it
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        clear = v.clr;
        #1;
        chk({tag, " gnt0"}, 32'(gnt0), 32'(v.eg0));
        chk({tag, " gnt1"}, 32'(gnt1), 32'(v.eg1));
        chk({tag, " ready"}, 32'(ready), 32'(v.erdy));
        @(posedge clk);
        #1;
        chk({tag, " rvalid0"}, 32'(rvalid0), 32'(v.ev0));
        chk({tag, " rvalid1"}, 32'(rvalid1), 32'(v.ev1));
        if (v.ev0) chk({tag, " rdata0"}, rdata0, v.ed0);
        if (v.ev1) chk({tag, " rdata1"}, rdata1, v.ed1);
    endtask

    // async reset wherever we are, then verify an 8-edge INIT
    task automatic reset_and_init(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, " rst ready"}, 32'(ready), 32'h0);
        chk({tag, " rst gnt0"}, 32'(gnt0), 32'h0);
        chk({tag, " rst gnt1"}, 32'(gnt1), 32'h0);
        chk({tag, " rst rvalid0"}, 32'(rvalid0), 32'h0);
        chk({tag, " rst rvalid1"}, 32'(rvalid1), 32'h0);
        chk({tag, " rst rdata0"}, rdata0, 32'h0);
        chk({tag, " rst rdata1"}, rdata1, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("%s init%0d ready", tag, i), 32'(ready), 32'h0);
            chk($sformatf("%s init%0d gnt0", tag, i), 32'(gnt0), 32'h0);
            @(negedge clk);
        end
        set_idle();
        #1;
        chk({tag, " init done ready"}, 32'(ready), 32'h1);
    endtask

    initial begin
        set_idle();
        #12;
        reset_and_init("boot");

        // preload every entry with nonzero data via client 1
        for (int a = 0; a < 8; a++) begin
            step(mk(0, 0, 0, 0, 1, 1, 3'(a), 32'hC0DE0000 + a,
                    0, 0, 1, 1, 0, 0, 0, 0), $sformatf("pre%0d", a));
        end
        reset_and_init("reinit");

        // first contended cycle after reset goes to client 0
        step(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0),
             "first_contend");
        for (int a = 0; a < 8; a++) begin
            step(mk(1, 0, 3'(a), 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0),
                 $sformatf("zrd%0d", a));
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),
                 $sformatf("zidle%0d", a));
        end

        // serve-phase table; rr_last is 0 here (client 0 last)
        tbl.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,
                         0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0,
                         0, 1, 0, 1, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0,
                         0, 0, 1, 1, 0, 0, 1, 32'hDEADBEEF));
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(mk(1, 1, 0, 32'h100 + i, 1, 1, 1, 32'h200 + i,
                             0, (i % 2 == 0), (i % 2 == 1), 1, 0, 0, 0, 0));
        end
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0,
                         0, 1, 0, 1, 1, 32'h104, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0,
                         0, 0, 1, 1, 0, 0, 1, 32'h205));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 7, 32'hA5A5A5A5,
                         0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0,
                         0, 0, 1, 1, 0, 0, 1, 32'hA5A5A5A5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2, 32'h1234,
                         1, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2, 32'h1234,
                             0, 0, 0, 0, 0, 0, 0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2, 32'h1234,
                         0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0,
                         0, 1, 0, 1, 1, 32'h1234, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,
                         0, 0, 1, 1, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0,
                         0, 0, 1, 1, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0,
                         0, 0, 1, 1, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0,
                         0, 0, 1, 1, 0, 0, 1, 32'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // reset landing in the middle of a clear sweep
        step(mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h1234, 0, 0),
             "mc_rd");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0),
             "mc_clr");
        chk("mc rdata0 held", rdata0, 32'h1234);
        set_idle();
        repeat (3) @(posedge clk);
        #2;
        req0 = 1'b1;
        reset_and_init("midclear");
        step(mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h0, 0, 0),
             "mc_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
